seg7_capture: RTL and testbench

- Reads the active-low 7-segment buses that our display path drives and recovers the hex digit each one shows.
- Per digit: a stability filter, then a pattern decoder, then a change detector.
- Changes are reported one at a time on a valid/ready stream.
- Used as an on-chip display monitor and as a self-check tap in keyboard/state-machine exercises.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_pattern_decode.sv | 47 ++++
 rtl/seg7_capture.sv | 153 +++++++++++++++
 tb/tb_seg7_capture.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture block: segment bit positions,
// the sixteen hex glyphs (active-high a..g), special codes and FSM states.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_ERR   = 5'd31;

  // Lit segments {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] PAT_0 = 7'h7E;
  localparam logic [6:0] PAT_1 = 7'h30;
  localparam logic [6:0] PAT_2 = 7'h6D;
  localparam logic [6:0] PAT_3 = 7'h79;
  localparam logic [6:0] PAT_4 = 7'h33;
  localparam logic [6:0] PAT_5 = 7'h5B;
  localparam logic [6:0] PAT_6 = 7'h5F;
  localparam logic [6:0] PAT_7 = 7'h70;
  localparam logic [6:0] PAT_8 = 7'h7F;
  localparam logic [6:0] PAT_9 = 7'h7B;
  localparam logic [6:0] PAT_A = 7'h77;
  localparam logic [6:0] PAT_B = 7'h1F;
  localparam logic [6:0] PAT_C = 7'h4E;
  localparam logic [6:0] PAT_D = 7'h3D;
  localparam logic [6:0] PAT_E = 7'h4F;
  localparam logic [6:0] PAT_F = 7'h47;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } rpt_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low segment byte into a hex code,
// blank/invalid marker and decimal-point flag.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pat,
  output logic [4:0] code,
  output logic       dp,
  output logic       err
);

  logic [6:0] lit;

  assign lit = {~pat[SEG_A], ~pat[SEG_B], ~pat[SEG_C], ~pat[SEG_D],
                ~pat[SEG_E], ~pat[SEG_F], ~pat[SEG_G]};
  assign dp  = ~pat[SEG_DP];

  // Match the lit a..g segments against the glyph table.
  always_comb begin
    code = CODE_ERR;
    err  = 1'b0;
    case (lit)
      PAT_0:   code = 5'd0;
      PAT_1:   code = 5'd1;
      PAT_2:   code = 5'd2;
      PAT_3:   code = 5'd3;
      PAT_4:   code = 5'd4;
      PAT_5:   code = 5'd5;
      PAT_6:   code = 5'd6;
      PAT_7:   code = 5'd7;
      PAT_8:   code = 5'd8;
      PAT_9:   code = 5'd9;
      PAT_A:   code = 5'd10;
      PAT_B:   code = 5'd11;
      PAT_C:   code = 5'd12;
      PAT_D:   code = 5'd13;
      PAT_E:   code = 5'd14;
      PAT_F:   code = 5'd15;
      7'h00:   code = CODE_BLANK;
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Display monitor: per-digit stability filter, pattern decode and change
// detection, with changes reported one at a time on a valid/ready stream.
//
// state   | meaning
// S_IDLE  | no report outstanding; picks next pending digit round-robin
// S_VALID | report held on out_*, waiting for out_ready
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIG          = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8*NDIG-1:0] seg_i,
  output logic [5*NDIG-1:0] code_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [4:0]        out_code,
  output logic              out_dp,
  output logic              out_err
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [NDIG-1:0]      commit, pending, pend_nxt, clr;
  logic [NDIG-1:0][4:0] dcode;
  logic [NDIG-1:0]      ddp, derr;

  rpt_state_t       state, state_nxt;
  logic             load, hs, found;
  logic [IDX_W-1:0] pick, rr, cand;

  for (genvar j = 0; j < NDIG; j++) begin : g_dig
    logic [7:0]       cur, samp, comm;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign cur = seg_i[8*j +: 8];

    // Run length of the current sample, saturating once it is accepted.
    always_comb begin
      if (cur != samp)         cnt_nxt = CNT_W'(1);
      else if (cnt == CNT_MAX) cnt_nxt = cnt;
      else                     cnt_nxt = cnt + CNT_W'(1);
    end

    // Saturation and a changed pattern only coincide on the reaching edge.
    assign commit[j] = (cnt_nxt == CNT_MAX) && (cur != comm);

    // Sample, run-length and committed-pattern registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        samp <= 8'hFF;
        cnt  <= '0;
        comm <= 8'hFF;
      end else begin
        samp <= cur;
        cnt  <= cnt_nxt;
        if (commit[j]) comm <= cur;
      end
    end

    seg7_pattern_decode u_dec (
      .pat  (comm),
      .code (dcode[j]),
      .dp   (ddp[j]),
      .err  (derr[j])
    );

    assign code_o[5*j +: 5] = dcode[j];
  end

  // First pending digit at or after the round-robin pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NDIG; k++) begin
      cand = IDX_W'((int'(rr) + k) % NDIG);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Report FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Report FSM next state and strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hs        = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          load      = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (out_ready) begin
          hs        = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign out_valid = (state == S_VALID);

  // Pending is released when its report is latched, so any commit arriving
  // while that report waits for the consumer produces a later report.
  always_comb begin
    clr = '0;
    if (load) clr[pick] = 1'b1;
    pend_nxt = commit | (pending & ~clr);
  end

  // Pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_nxt;
  end

  // Report payload and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx  <= '0;
      out_code <= '0;
      out_dp   <= 1'b0;
      out_err  <= 1'b0;
      rr       <= '0;
    end else begin
      if (load) begin
        out_idx  <= pick;
        out_code <= dcode[pick];
        out_dp   <= ddp[pick];
        out_err  <= derr[pick];
      end
      if (hs) rr <= (out_idx == IDX_W'(NDIG - 1)) ? '0 : out_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a transaction-level model predicts
// committed codes and the report sequence; a monitor checks each handshake.
module tb_seg7_capture;

  localparam int NDIG   = 2;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] seg_i;
  logic [9:0]  code_o;
  logic        out_valid, out_ready;
  logic [0:0]  out_idx;
  logic [4:0]  out_code;
  logic        out_dp, out_err;

  always #5 clk = ~clk;

  seg7_capture #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_i     (seg_i),
    .code_o    (code_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_code  (out_code),
    .out_dp    (out_dp),
    .out_err   (out_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  logic [6:0] pat_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Returns {code[4:0], dp, err} for an active-low segment byte.
  function automatic logic [6:0] ref_dec(input logic [7:0] s);
    logic [7:0] a;
    logic [4:0] c;
    logic       e;
    a = ~s;
    c = 5'd31;
    e = 1'b1;
    if (a[7:1] == 7'h00) begin c = 5'd16; e = 1'b0; end
    for (int k = 0; k < 16; k++)
      if (a[7:1] == pat_tab[k]) begin c = 5'(k); e = 1'b0; end
    return {c, a[0], e};
  endfunction

  typedef struct {
    int idx;
    int code;
    int dp;
    int err;
  } rep_t;

  rep_t       exp_q[$];
  logic [7:0] m_last [NDIG];
  logic [7:0] m_comm [NDIG];
  int         m_run  [NDIG];
  bit         m_pend [NDIG];
  bit         m_busy;
  int         m_rr, m_cur, m_sel;
  logic [6:0] m_d;
  logic [7:0] m_v;

  // Reference model: changes accepted after STABLE identical samples; each
  // changed digit owed one report; reports issued round-robin, one in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NDIG; j++) begin
        m_last[j] = 8'hFF;
        m_comm[j] = 8'hFF;
        m_run[j]  = 0;
        m_pend[j] = 1'b0;
      end
      m_busy = 1'b0;
      m_rr   = 0;
      m_cur  = 0;
      exp_q.delete();
    end else begin
      if (m_busy && out_ready) begin
        m_busy = 1'b0;
        m_rr   = (m_cur + 1) % NDIG;
      end else if (!m_busy) begin
        m_sel = -1;
        for (int k = 0; k < NDIG; k++)
          if (m_sel < 0 && m_pend[(m_rr + k) % NDIG]) m_sel = (m_rr + k) % NDIG;
        if (m_sel >= 0) begin
          m_d = ref_dec(m_comm[m_sel]);
          exp_q.push_back('{m_sel, int'(m_d[6:2]), int'(m_d[1]), int'(m_d[0])});
          m_pend[m_sel] = 1'b0;
          m_busy = 1'b1;
          m_cur  = m_sel;
        end
      end
      for (int j = 0; j < NDIG; j++) begin
        m_v = seg_i[8*j +: 8];
        if (m_v != m_last[j]) begin
          m_last[j] = m_v;
          m_run[j]  = 1;
        end else if (m_run[j] < 1000) begin
          m_run[j]++;
        end
        if (m_run[j] == STABLE && m_v != m_comm[j]) begin
          m_comm[j] = m_v;
          m_pend[j] = 1'b1;
        end
      end
    end
  end

  logic [9:0] mon_codes;
  logic [6:0] mon_d;
  rep_t       mon_e;

  // Monitor: committed codes every cycle, report payload on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < NDIG; j++) begin
        mon_d = ref_dec(m_comm[j]);
        mon_codes[5*j +: 5] = mon_d[6:2];
      end
      check("code_o", int'(code_o), int'(mon_codes));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_report", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rep_idx",  int'(out_idx),  mon_e.idx);
          check("rep_code", int'(out_code), mon_e.code);
          check("rep_dp",   int'(out_dp),   mon_e.dp);
          check("rep_err",  int'(out_err),  mon_e.err);
        end
      end
    end
  end

  task automatic hold(input logic [15:0] v, input int n);
    seg_i = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] rand_seg();
    int         r;
    logic [7:0] t;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      t = {pat_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
      return ~t;
    end else if (r < 8) begin
      return 8'hFF;
    end
    return 8'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur;
    rst_n     = 1'b1;
    seg_i     = 16'hFFFF;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_code_o", int'(code_o), 10'h210);
    check("reset_valid",  int'(out_valid), 0);
    check("reset_idx",    int'(out_idx), 0);
    check("reset_code",   int'(out_code), 0);
    check("reset_dp_err", int'({out_dp, out_err}), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    hold(16'hFFFF, 10);
    check("idle_no_report", int'(out_valid), 0);

    // Commit latency and report timing.
    out_ready = 1'b1;
    seg_i = 16'hFF25;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    check("lat_code_o",    int'(code_o[4:0]), 2);
    check("lat_valid_pre", int'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_valid", int'(out_valid), 1);
    check("lat_idx",   int'(out_idx), 0);
    check("lat_code",  int'(out_code), 2);
    check("lat_dp",    int'(out_dp), 0);
    check("lat_err",   int'(out_err), 0);
    #1;
    hold(16'hFF25, 4);

    // Short glitch is filtered, only the stable value is reported.
    hold(16'hFFFF, 6);
    hold(16'hFF25, 3);
    hold(16'hFF9F, 6);

    // Back-pressure: second change waits behind the first.
    out_ready = 1'b0;
    hold(16'h0D9F, 6);
    hold(16'h1F9F, 6);
    check("held_valid", int'(out_valid), 1);
    check("held_idx",   int'(out_idx), 1);
    check("held_code",  int'(out_code), 3);
    out_ready = 1'b1;
    hold(16'h1F9F, 8);

    // Simultaneous commits, invalid pattern, all-lit with dp.
    hold(16'h7111, 10);
    hold(16'h71FD, 8);
    hold(16'h7100, 8);

    // Randomized traffic with random back-pressure.
    cur = 16'h7100;
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < NDIG; j++)
        if ($urandom_range(0, 3) == 0) cur[8*j +: 8] = rand_seg();
      out_ready = ($urandom_range(0, 3) != 0);
      seg_i = cur;
      @(posedge clk);
      #2;
    end

    // Drain outstanding reports.
    out_ready = 1'b1;
    hold(16'hFFFF, 20);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #2;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", int'(out_valid), 0);

    // Reset while a report is held.
    out_ready = 1'b0;
    seg_i = 16'hFF25;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #2;
    end
    check("rst_wait_valid", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid_drop", int'(out_valid), 0);
    check("rst_code_o",     int'(code_o), 10'h210);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    seg_i = 16'hFFFF;
    hold(16'hFFFF, 5);
    check("post_rst_valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
